// File: rtl/router_pkt_tx.sv
// router_pkt_tx: host-side packet transmitter for the router input port.
// Collects the payload into an internal buffer first, so a packet is never
// starved mid-stream. It then sends the header {len,addr}, the payload bytes
// and a parity byte on data_out/pkt_valid, honouring the router's busy stall.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                build request (sampled in IDLE only)
//   dest_addr[1:0]       destination 0..2 (3 is rejected)
//   payload_len[5:0]     payload byte count 0..MAX_LEN
//   pl_data/pl_valid     payload byte source
//   pl_ready             high while collecting payload (LOAD)
//   busy                 router stall; a byte is consumed when busy=0
//   data_out[7:0]        registered byte to the router
//   pkt_valid            high for header/payload, low for parity
//   tx_active            high whenever not IDLE
//   done/abort/reject    one-cycle status pulses
//
// Optional feature: define ROUTER_PKT_TX_PARITY_ERR_EN to add input
// corrupt_par; when latched high at start, the sent parity byte is inverted.
module router_pkt_tx #(
  parameter int MAX_LEN = 63,
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
  input  logic       corrupt_par,
`endif
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       done,
  output logic       abort,
  output logic       reject
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY} state_t;

  state_t          state, state_nx;
  logic [7:0]      mem [MAX_LEN];
  logic [IW-1:0]   idx;
  logic [TW-1:0]   tcnt;
  logic [7:0]      par;
  logic [7:0]      par_out;
  logic [1:0]      addr_q;
  logic [5:0]      len_q;
  logic            start_ok;
  logic            last_byte;
  logic            timeout_hit;

  assign start_ok    = start && (dest_addr != 2'd3);
  // idx points at the byte being loaded (LOAD) or presented (PAYLOAD)
  assign last_byte   = (6'(idx) == len_q - 6'd1);
  assign timeout_hit = busy && (tcnt == TO_LAST);

`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
  logic corrupt_q;
  assign par_out = par ^ {8{corrupt_q}};
`else
  assign par_out = par;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start_ok) state_nx = (payload_len == 6'd0) ? HEADER : LOAD;
      LOAD:
        if (pl_valid && last_byte) state_nx = HEADER;
      HEADER:
        if (timeout_hit)  state_nx = IDLE;
        else if (!busy)   state_nx = (len_q == 6'd0) ? PARITY : PAYLOAD;
      PAYLOAD:
        if (timeout_hit)            state_nx = IDLE;
        else if (!busy && last_byte) state_nx = PARITY;
      PARITY:
        if (timeout_hit || !busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    pl_ready  = (state == LOAD);
    tx_active = (state != IDLE);
  end

  // Payload buffer (contents need no reset)
  always_ff @(posedge clk) begin
    if (state == LOAD && pl_valid) mem[idx] <= pl_data;
  end

  // Datapath: data_out is loaded with the byte for the state being entered,
  // so it is already valid on the first cycle of that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
      reject    <= 1'b0;
      idx       <= '0;
      tcnt      <= '0;
      par       <= '0;
      addr_q    <= '0;
      len_q     <= '0;
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
      corrupt_q <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      abort  <= 1'b0;
      reject <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && dest_addr == 2'd3) begin
            reject <= 1'b1;
          end else if (start) begin
            addr_q <= dest_addr;
            len_q  <= payload_len;
            par    <= {payload_len, dest_addr};
            idx    <= '0;
            tcnt   <= '0;
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
            corrupt_q <= corrupt_par;
`endif
            if (payload_len == 6'd0) begin
              data_out  <= {payload_len, dest_addr};
              pkt_valid <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (pl_valid) begin
            par <= par ^ pl_data;
            if (last_byte) begin
              idx       <= '0;
              data_out  <= {len_q, addr_q};
              pkt_valid <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HEADER, PAYLOAD, PARITY: begin
          if (busy) begin
            if (timeout_hit) begin
              abort     <= 1'b1;
              pkt_valid <= 1'b0;
              data_out  <= '0;
              tcnt      <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end else begin
            tcnt <= '0;
            if (state == HEADER) begin
              if (len_q == 6'd0) begin
                data_out  <= par_out;
                pkt_valid <= 1'b0;
              end else begin
                data_out <= mem[idx];
              end
            end else if (state == PAYLOAD) begin
              if (last_byte) begin
                data_out  <= par_out;
                pkt_valid <= 1'b0;
              end else begin
                data_out <= mem[idx + IW'(1)];
                idx      <= idx + IW'(1);
              end
            end else begin
              data_out  <= '0;
              pkt_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_active;
  logic       done;
  logic       abort;
  logic       reject;
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
  logic       corrupt_par;
  localparam logic [7:0] PAR1 = 8'h22;
`else
  localparam logic [7:0] PAR1 = 8'hDD;
`endif

  int unsigned n_cmp;
  int unsigned n_bad;

  router_pkt_tx #(.MAX_LEN(63), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .busy        (busy),
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
    .corrupt_par (corrupt_par),
`endif
    .data_out    (data_out),
    .pkt_valid   (pkt_valid),
    .tx_active   (tx_active),
    .done        (done),
    .abort       (abort),
    .reject      (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // data_out, pkt_valid, done, tx_active in one compact check
  task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                         input logic dn, input logic act);
    check({tag, ".data"},   {24'd0, data_out}, {24'd0, d});
    check({tag, ".valid"},  {31'd0, pkt_valid}, {31'd0, v});
    check({tag, ".done"},   {31'd0, done}, {31'd0, dn});
    check({tag, ".active"}, {31'd0, tx_active}, {31'd0, act});
  endtask

  task automatic issue(input logic [1:0] a, input logic [5:0] l);
    start = 1'b1; dest_addr = a; payload_len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input logic [7:0] b);
    pl_valid = 1'b1; pl_data = b;
    tick();
    pl_valid = 1'b0; pl_data = 8'h00;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; dest_addr = 2'd0; payload_len = 6'd0;
    pl_data = 8'h00; pl_valid = 1'b0; busy = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
    corrupt_par = 1'b1;
`endif
    #1;
    chk_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst.pl_ready", {31'd0, pl_ready}, 32'd0);
    check("rst.abort", {31'd0, abort}, 32'd0);
    check("rst.reject", {31'd0, reject}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // 1: addr=1 len=3, no stall
    issue(2'd1, 6'd3);
`ifdef ROUTER_PKT_TX_PARITY_ERR_EN
    corrupt_par = 1'b0;
`endif
    check("p1.ready0", {31'd0, pl_ready}, 32'd1);
    check("p1.active0", {31'd0, tx_active}, 32'd1);
    load(8'hA1);
    load(8'hB2);
    check("p1.ready2", {31'd0, pl_ready}, 32'd1);
    load(8'hC3);
    check("p1.ready3", {31'd0, pl_ready}, 32'd0);
    chk_out("p1.hdr", 8'h0D, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p1.b0", 8'hA1, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p1.b1", 8'hB2, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p1.b2", 8'hC3, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p1.par", PAR1, 1'b0, 1'b0, 1'b1);
    tick(); chk_out("p1.done", 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); chk_out("p1.idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // 2: same packet, two stall cycles on B2 (source gap in LOAD too)
    issue(2'd1, 6'd3);
    load(8'hA1);
    tick();
    check("p2.gap_ready", {31'd0, pl_ready}, 32'd1);
    load(8'hB2);
    load(8'hC3);
    chk_out("p2.hdr", 8'h0D, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p2.b0", 8'hA1, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p2.b1a", 8'hB2, 1'b1, 1'b0, 1'b1);
    busy = 1'b1;
    tick(); chk_out("p2.b1b", 8'hB2, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p2.b1c", 8'hB2, 1'b1, 1'b0, 1'b1);
    busy = 1'b0;
    tick(); chk_out("p2.b2", 8'hC3, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p2.par", 8'hDD, 1'b0, 1'b0, 1'b1);
    tick(); chk_out("p2.done", 8'h00, 1'b0, 1'b1, 1'b0);

    // 3: addr=2 len=0 goes straight to HEADER
    issue(2'd2, 6'd0);
    check("p3.ready", {31'd0, pl_ready}, 32'd0);
    chk_out("p3.hdr", 8'h02, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p3.par", 8'h02, 1'b0, 1'b0, 1'b1);
    tick(); chk_out("p3.done", 8'h00, 1'b0, 1'b1, 1'b0);

    // 4: illegal address
    issue(2'd3, 6'd2);
    check("p4.reject", {31'd0, reject}, 32'd1);
    check("p4.ready", {31'd0, pl_ready}, 32'd0);
    check("p4.active", {31'd0, tx_active}, 32'd0);
    tick();
    check("p4.reject_off", {31'd0, reject}, 32'd0);
    check("p4.active2", {31'd0, tx_active}, 32'd0);

    // 5: timeout, busy held from HEADER (TIMEOUT=4)
    issue(2'd1, 6'd1);
    busy = 1'b1;
    load(8'h5A);
    chk_out("p5.hdr", 8'h05, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    chk_out("p5.hold3", 8'h05, 1'b1, 1'b0, 1'b1);
    check("p5.no_abort3", {31'd0, abort}, 32'd0);
    tick();
    check("p5.abort", {31'd0, abort}, 32'd1);
    chk_out("p5.aborted", 8'h00, 1'b0, 1'b0, 1'b0);
    busy = 1'b0;
    tick();
    check("p5.abort_off", {31'd0, abort}, 32'd0);
    chk_out("p5.idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // 6: async reset mid-PAYLOAD, then a clean packet
    issue(2'd1, 6'd3);
    load(8'hA1); load(8'hB2); load(8'hC3);
    tick();
    chk_out("p6.b0", 8'hA1, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_out("p6.rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check("p6.rst_ready", {31'd0, pl_ready}, 32'd0);
    #1 rst = 1'b0;
    issue(2'd0, 6'd2);
    load(8'h11); load(8'h22);
    chk_out("p6.hdr", 8'h08, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p6.n0", 8'h11, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p6.n1", 8'h22, 1'b1, 1'b0, 1'b1);
    tick(); chk_out("p6.par", 8'h3B, 1'b0, 1'b0, 1'b1);
    tick(); chk_out("p6.done", 8'h00, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet transmitter for the router input side. It builds and sends packets in the format the router FIFOs store and decode.
- Packet format: header byte {payload_len[5:0], dest_addr[1:0]}, then payload_len payload bytes, then one parity byte.
- Payload is first collected from a byte source into an internal buffer, so a packet never stalls mid-stream on the source.
- Used as the stimulus/host-side engine that drives the router's data_in / pkt_valid / busy interface.

Parameters:
- MAX_LEN, 63, internal buffer depth in bytes; equals the largest legal payload_len.
- TIMEOUT, 30, number of consecutive busy cycles that triggers an abort during transmission.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to build a packet; sampled only in IDLE.
- dest_addr  in  2  destination port 0..2; 3 is illegal.
- payload_len  in  6  payload byte count, 0..MAX_LEN.
- pl_data  in  8  payload byte from the source.
- pl_valid  in  1  pl_data valid.
- pl_ready  out  1  transmitter accepts pl_data.
- busy  in  1  router stall; a byte is consumed only on an edge where busy=0.
- data_out  out  8  byte to the router (registered).
- pkt_valid  out  1  high during header and payload bytes, low during the parity byte.
- tx_active  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the parity byte is consumed.
- abort  out  1  one-cycle pulse on timeout.
- reject  out  1  one-cycle pulse when start is given with dest_addr==3.

Behaviour:
- Reset (async, any state): state=IDLE; data_out=0; pkt_valid, pl_ready, tx_active, done, abort, reject all 0; counters and parity accumulator cleared. Buffer contents are don't-care.
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY.
- IDLE:
  - start=1 and dest_addr==3: reject=1 next cycle; stay IDLE.
  - start=1 and addr legal: latch addr and len; parity accumulator = header byte.
  - If len>0, go to LOAD; if len==0, go directly to HEADER.
- LOAD:
  - pl_ready=1.
  - Each edge with pl_valid=1 writes pl_data to buf[idx], XORs it into parity, and increments idx.
  - After the len-th byte, pl_ready drops and state goes to HEADER. No extra bytes are accepted.
  - Source gaps are allowed; there is no timeout in LOAD.
- HEADER:
  - data_out = {len, addr}; pkt_valid=1.
  - When busy=0 at the edge: go to PAYLOAD (idx=0), or to PARITY if len==0.
- PAYLOAD:
  - data_out = buf[idx]; pkt_valid=1.
  - Each consumed byte advances idx. After the last byte, go to PARITY.
- PARITY:
  - data_out = parity (XOR of header and all payload bytes); pkt_valid=0.
  - When consumed: go to IDLE and pulse done=1 for one cycle.
- Stall rule: while busy=1, data_out and pkt_valid hold their values and the state does not advance.
- Latency: header appears on the cycle after the last payload byte is loaded (or after start when len==0). With busy=0 throughout, one byte is sent per cycle, for a total of len+2 cycles on the router side.
- Timeout (HEADER/PAYLOAD/PARITY only):
  - A counter increments on each busy=1 cycle and clears on each consumed byte.
  - When the count reaches TIMEOUT: abort pulse, pkt_valid=0, data_out=0, state=IDLE. The partial packet is discarded and done is not pulsed.
- start while not IDLE is ignored.
- Simultaneous events: timeout and byte consumption cannot coincide, because consumption requires busy=0.
- Index width: ceil(log2(MAX_LEN+1)) bits; idx never wraps past len.

Optional Feature:
- Macro: ROUTER_PKT_TX_PARITY_ERR_EN.
- Defined: adds input corrupt_par (1 bit), latched at start acceptance. When the latched value is 1, the transmitted parity byte is bit-inverted, to exercise the router's parity-error path. The internal accumulator is unaffected.
- Undefined: the port is absent and parity is always correct.

Test Plan:
- addr=1, len=3, payload A1,B2,C3, busy=0 -> 3 load cycles; then data_out 0D,A1,B2,C3 with pkt_valid=1; then DD with pkt_valid=0; done pulses the following cycle.
- Same packet with busy=1 for 2 cycles while B2 is presented -> B2 held 3 cycles with pkt_valid=1; sequence and parity DD unchanged.
- addr=2, len=0 -> no LOAD; data_out 02 (pkt_valid=1), then 02 (pkt_valid=0); done pulses.
- start with addr=3 -> reject pulse; pl_ready stays 0; tx_active stays 0.
- TIMEOUT=4, busy held high from HEADER -> abort after 4 busy cycles; pkt_valid=0, data_out=0, IDLE, no done.
- rst asserted mid-PAYLOAD -> all outputs 0 immediately (no clock edge needed); the next packet after release is sent correctly. With the macro defined and corrupt_par=1, the first scenario ends with parity 22.
